// File: rtl/pid_pos_controller.sv
// Discrete PID position loop: one sample every CLK_DIV clocks, PWM duty magnitude + direction out.
// Latency: out_valid 4 cycles after the sample tick; no backpressure (fire-and-forget pulse).
// Optional deadband on |err| enabled by defining PID_DEADBAND_EN (uses DEADBAND).
module pid_pos_controller #(
    parameter int CLK_DIV   = 100000,
    parameter int OUT_W     = 12,
    parameter int INT_LIMIT = 1000000,
    parameter int DEADBAND  = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              enable,
    input  logic [15:0]       kp_init,
    input  logic [15:0]       ki_init,
    input  logic [15:0]       kd_init,
    input  logic [31:0]       desired_pos,
    input  logic [31:0]       actual_pos,
    output logic [OUT_W-1:0]  duty,
    output logic              dir,
    output logic              out_valid,
    output logic              busy
);

    localparam int CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [CNT_W-1:0]    TICK_LAST = CNT_W'(CLK_DIV - 1);
    localparam logic signed [32:0]  INT_HI    = 33'(INT_LIMIT);
    localparam logic signed [32:0]  INT_LO    = -33'(INT_LIMIT);
    localparam logic signed [50:0]  DUTY_MAX  = (51'sd1 <<< OUT_W) - 51'sd1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ERR,
        S_MUL,
        S_SUM,
        S_SAT
    } state_t;

    state_t                 state;
    logic [CNT_W-1:0]       tick_cnt;
    logic                   tick;

    logic [15:0]            kp_r, ki_r, kd_r;
    logic signed [31:0]     des_r, act_r;
    logic signed [31:0]     integ, prev_err;
    logic signed [31:0]     err_r, derr_r, integ_nx_r;
    logic signed [48:0]     pterm, iterm, dterm;

    logic signed [32:0]     err33, derr33, integ33;
    logic signed [31:0]     err_sat, err_eff, derr_sat, integ_nx;
    logic signed [50:0]     u_sum, u_shr, u_mag;

    function automatic logic signed [31:0] sat32(input logic signed [32:0] v);
        if (v[32] != v[31])
            return v[32] ? 32'sh8000_0000 : 32'sh7FFF_FFFF;
        return v[31:0];
    endfunction

    assign tick = (tick_cnt == TICK_LAST);
    assign busy = (state != S_IDLE);

    // Error path, evaluated from the sampled inputs while in S_ERR.
    always_comb begin
        err33   = 33'(des_r) - 33'(act_r);
        err_sat = sat32(err33);
        err_eff = err_sat;
        integ33 = 33'(integ) + 33'(err_sat);
`ifdef PID_DEADBAND_EN
        if ((err_sat <= 32'(DEADBAND)) && (err_sat >= -32'(DEADBAND))) begin
            err_eff = '0;
            integ33 = 33'(integ);
        end
`endif
        derr33   = 33'(err_eff) - 33'(prev_err);
        derr_sat = sat32(derr33);
        if (integ33 > INT_HI)
            integ_nx = INT_HI[31:0];
        else if (integ33 < INT_LO)
            integ_nx = INT_LO[31:0];
        else
            integ_nx = integ33[31:0];
    end

    always_comb begin
        u_sum = 51'(pterm) + 51'(iterm) + 51'(dterm);
        u_shr = u_sum >>> 8;
        u_mag = u_shr[50] ? -u_shr : u_shr;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= S_IDLE;
            tick_cnt   <= '0;
            duty       <= '0;
            dir        <= 1'b0;
            out_valid  <= 1'b0;
            integ      <= '0;
            prev_err   <= '0;
            kp_r       <= '0;
            ki_r       <= '0;
            kd_r       <= '0;
            des_r      <= '0;
            act_r      <= '0;
            err_r      <= '0;
            derr_r     <= '0;
            integ_nx_r <= '0;
            pterm      <= '0;
            iterm      <= '0;
            dterm      <= '0;
        end else if (!enable) begin
            state     <= S_IDLE;
            tick_cnt  <= '0;
            duty      <= '0;
            dir       <= 1'b0;
            out_valid <= 1'b0;
            integ     <= '0;
            prev_err  <= '0;
        end else begin
            tick_cnt  <= tick ? '0 : tick_cnt + 1'b1;
            out_valid <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (tick) begin
                        kp_r  <= kp_init;
                        ki_r  <= ki_init;
                        kd_r  <= kd_init;
                        des_r <= desired_pos;
                        act_r <= actual_pos;
                        state <= S_ERR;
                    end
                end
                S_ERR: begin
                    err_r      <= err_eff;
                    derr_r     <= derr_sat;
                    integ_nx_r <= integ_nx;
                    state      <= S_MUL;
                end
                S_MUL: begin
                    pterm <= 49'($signed({1'b0, kp_r})) * 49'(err_r);
                    iterm <= 49'($signed({1'b0, ki_r})) * 49'(integ_nx_r);
                    dterm <= 49'($signed({1'b0, kd_r})) * 49'(derr_r);
                    state <= S_SUM;
                end
                S_SUM: begin
                    // Outputs land on the edge into S_SAT so out_valid is high during S_SAT.
                    dir       <= u_shr[50];
                    duty      <= (u_mag > DUTY_MAX) ? DUTY_MAX[OUT_W-1:0] : u_mag[OUT_W-1:0];
                    out_valid <= 1'b1;
                    state     <= S_SAT;
                end
                S_SAT: begin
                    prev_err <= err_r;
                    integ    <= integ_nx_r;
                    state    <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_pid_pos_controller.sv
// Scoreboard bench for pid_pos_controller: expected duty/dir pushed with stimulus, popped by a monitor.
module tb_pid_pos_controller;

    localparam int OUT_W = 12;

    logic              clk = 1'b0;
    logic              reset;
    logic              enable;
    logic [15:0]       kp, ki, kd;
    logic [31:0]       desired, actual;
    logic [OUT_W-1:0]  duty;
    logic              dir;
    logic              out_valid;
    logic              busy;

    typedef struct packed {
        logic [OUT_W-1:0] duty;
        logic             dir;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    pid_pos_controller #(
        .CLK_DIV   (10),
        .OUT_W     (OUT_W),
        .INT_LIMIT (1000000),
        .DEADBAND  (4)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .enable      (enable),
        .kp_init     (kp),
        .ki_init     (ki),
        .kd_init     (kd),
        .desired_pos (desired),
        .actual_pos  (actual),
        .duty        (duty),
        .dir         (dir),
        .out_valid   (out_valid),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input longint act, input longint req);
        n_cmp++;
        if (act != req) begin
            n_bad++;
            $display("FAIL %s: got %0d, want %0d", name, act, req);
        end
    endtask

    task automatic push(input int d, input bit r);
        exp_t e;
        e.duty = OUT_W'(d);
        e.dir  = r;
        exp_q.push_back(e);
    endtask

    task automatic drain(input string name);
        for (int i = 0; i < 200 && exp_q.size() != 0; i++)
            @(posedge clk);
        if (exp_q.size() != 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL %s_timeout: got %0d pending outputs, want 0", name, exp_q.size());
            exp_q.delete();
        end
        #1;
    endtask

    always @(negedge clk) begin : monitor
        exp_t e;
        if (out_valid) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_out_valid: got pulse duty=%0d dir=%0d, want no pulse", duty, dir);
            end else begin
                e = exp_q.pop_front();
                check("duty", duty, e.duty);
                check("dir", dir, e.dir);
            end
        end
    end

    initial begin
        bit seen;
        reset   = 1'b1;
        enable  = 1'b0;
        kp      = '0;
        ki      = '0;
        kd      = '0;
        desired = '0;
        actual  = '0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_duty", duty, 0);
        check("reset_dir", dir, 0);
        check("reset_out_valid", out_valid, 0);
        check("reset_busy", busy, 0);
        reset = 1'b0;

        // Pure proportional, positive error.
        kp = 16'h0100; desired = 32'd1000; actual = 32'd0;
        push(1000, 0);
        enable = 1'b1;
        drain("p_pos");

        // Large negative error saturates duty and sets reverse.
        desired = 32'd0; actual = 32'd5000;
        push(4095, 1);
        drain("p_sat_neg");

        // Reset while in S_MUL: no pulse, outputs cleared, FSM idle.
        desired = 32'd1000; actual = 32'd0;
        seen = 1'b0;
        for (int i = 0; i < 30 && !seen; i++) begin
            @(posedge clk);
            #1;
            seen = busy;
        end
        check("busy_seen", seen, 1);
        @(posedge clk);
        #1;
        reset  = 1'b1;
        enable = 1'b0;
        @(posedge clk);
        #1;
        check("midreset_duty", duty, 0);
        check("midreset_dir", dir, 0);
        check("midreset_busy", busy, 0);
        check("midreset_out_valid", out_valid, 0);
        reset = 1'b0;
        repeat (20) @(posedge clk);
        #1;

        // Integral accumulates a constant error; disabling clears it.
        kp = '0; ki = 16'h0100; desired = 32'd10; actual = 32'd0;
        push(10, 0); push(20, 0); push(30, 0);
        enable = 1'b1;
        drain("integ");
        enable = 1'b0;
        @(posedge clk);
        #1;
        check("disable_duty", duty, 0);
        check("disable_dir", dir, 0);
        check("disable_integ", dut.integ, 0);
        check("disable_prev_err", dut.prev_err, 0);

        // Derivative: step 0 -> 100 then hold.
        ki = '0; kd = 16'h0100; desired = 32'd0; actual = 32'd0;
        push(0, 0);
        enable = 1'b1;
        drain("deriv_zero");
        desired = 32'd100;
        push(100, 0);
        drain("deriv_step");
        push(0, 0);
        drain("deriv_hold");
        enable = 1'b0;
        @(posedge clk);
        #1;

        // Small error: suppressed with deadband, PI-active without it.
        kp = 16'h0100; ki = 16'h0100; kd = '0; desired = 32'd3; actual = 32'd0;
`ifdef PID_DEADBAND_EN
        for (int i = 0; i < 5; i++) push(0, 0);
        enable = 1'b1;
        drain("deadband_in");
        check("deadband_integ", dut.integ, 0);
        desired = 32'd5;
        push(10, 0);
        drain("deadband_out");
`else
        push(6, 0); push(9, 0);
        enable = 1'b1;
        drain("small_err");
        check("small_err_integ", dut.integ, 6);
`endif
        enable = 1'b0;
        repeat (3) @(posedge clk);
        #1;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
